// File: rtl/aha_clock_divider_switch_if.sv
// Divisor-change handshake and divided-clock status bundle for aha_clock_divider_switch.
// The requester side uses the master modport; the divider uses the slave modport.
interface aha_clock_divider_switch_if #(
    parameter int DIV_W = 4
);
    logic             select_req;
    logic [DIV_W-1:0] select_div;
    logic             select_ack;
    logic             clk_out;
    logic [DIV_W-1:0] div_cur;
    logic             stopped;

    modport master (
        output select_req,
        output select_div,
        input  select_ack,
        input  clk_out,
        input  div_cur,
        input  stopped
    );

    modport slave (
        input  select_req,
        input  select_div,
        output select_ack,
        output clk_out,
        output div_cur,
        output stopped
    );
endinterface

// File: rtl/aha_clock_divider_switch.sv
// Glitch-free programmable clock divider: passes one CLK high phase every div_cur cycles,
// with run-time ratio changes through a 4-phase handshake applied on period boundaries.
module aha_clock_divider_switch #(
    parameter int          DIV_W       = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned RESET_DIV   = 1
) (
    input logic                        CLK,
    input logic                        RESETn,
    aha_clock_divider_switch_if.slave  bus
);
    localparam logic [DIV_W-1:0] RST_DIV = RESET_DIV[DIV_W-1:0];
    localparam logic [DIV_W-1:0] ONE     = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             ack_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic             req_s;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic             is_stopped;
    logic             boundary;
    logic             tick;
    logic             gate;

    assign req_s      = sync_q[SYNC_STAGES-1];
    assign is_stopped = (div_q == '0);
    assign boundary   = !is_stopped && (cnt == (div_q - ONE));
    assign tick       = (cnt == '0) && !is_stopped;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.select_req};
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= S_IDLE;
            ack_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ack_q <= (state_nxt == S_ACK);
        end
    end

    // A stopped clock has no boundary, so the load happens on the first WAIT cycle.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_s) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (boundary || is_stopped) begin
                    state_nxt = S_ACK;
                    load      = 1'b1;
                end
            end
            S_ACK: begin
                if (!req_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt   <= '0;
            div_q <= RST_DIV;
        end else if (load) begin
            cnt   <= '0;
            div_q <= bus.select_div;
        end else if (is_stopped || boundary) begin
            cnt   <= '0;
        end else begin
            cnt   <= cnt + ONE;
        end
    end

    // Gate moves only while CLK is low, so the AND below never produces a runt.
    always_ff @(negedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            gate <= 1'b0;
        end else begin
            gate <= tick;
        end
    end

    assign bus.clk_out    = CLK & gate;
    assign bus.select_ack = ack_q;
    assign bus.div_cur    = div_q;
    assign bus.stopped    = is_stopped;
endmodule

// File: tb/tb_aha_clock_divider_switch.sv
// Directed bench for aha_clock_divider_switch: handshake timing, pulse spacing, stop/restart,
// mid-handshake reset and pulse-width integrity of the divided clock.
module tb_aha_clock_divider_switch;
    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    int   vecs = 0;
    int   errs = 0;
    time  t_rise;

    always #5 CLK = ~CLK;

    aha_clock_divider_switch_if #(.DIV_W(4)) bus ();

    aha_clock_divider_switch #(
        .DIV_W      (4),
        .SYNC_STAGES(2),
        .RESET_DIV  (1)
    ) dut (
        .CLK   (CLK),
        .RESETn(RESETn),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic stepchk(input string tag, input logic c, input logic a);
        step();
        chk({tag, "_clk"}, {31'b0, bus.clk_out}, {31'b0, c});
        chk({tag, "_ack"}, {31'b0, bus.select_ack}, {31'b0, a});
    endtask

    task automatic wait_hi(input string tag);
        int n;
        n = 0;
        while (bus.clk_out !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(tag, {31'b0, bus.clk_out}, 32'd1);
    endtask

    task automatic handshake(input logic [3:0] d);
        int n;
        bus.select_div = d;
        bus.select_req = 1'b1;
        n = 0;
        while (bus.select_ack !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("hs_ack_rise", {31'b0, bus.select_ack}, 32'd1);
        chk("hs_div_load", {28'b0, bus.div_cur}, {28'b0, d});
        bus.select_req = 1'b0;
        n = 0;
        while (bus.select_ack !== 1'b0 && n < 10) begin
            step();
            n++;
        end
        chk("hs_ack_fall", n, 32'd3);
    endtask

    task automatic measure(input string tag, input int d);
        int n;
        n = 0;
        while (bus.clk_out !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n = 0;
        do begin
            step();
            n++;
        end while (bus.clk_out !== 1'b1 && n < 40);
        chk(tag, n, d);
    endtask

    always @(posedge bus.clk_out) begin
        t_rise = $time;
        chk("pulse_align", {31'b0, CLK}, 32'd1);
        @(negedge bus.clk_out);
        if (RESETn) chk("pulse_width", 32'($time - t_rise), 32'd5);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] d;
        bus.select_req = 1'b0;
        bus.select_div = 4'd0;

        // reset state
        step();
        step();
        chk("rst_clk_out", {31'b0, bus.clk_out}, 32'd0);
        chk("rst_ack", {31'b0, bus.select_ack}, 32'd0);
        chk("rst_stopped", {31'b0, bus.stopped}, 32'd0);
        chk("rst_div_cur", {28'b0, bus.div_cur}, 32'd1);
        RESETn = 1'b1;

        // divide by 1 follows CLK
        for (int i = 0; i < 4; i++) stepchk("t1", 1'b1, 1'b0);
        @(negedge CLK);
        #2;
        chk("t1_low_phase", {31'b0, bus.clk_out}, 32'd0);

        // 1 -> 3, cycle exact
        step();
        bus.select_div = 4'd3;
        bus.select_req = 1'b1;
        stepchk("t2_c1", 1'b1, 1'b0);
        stepchk("t2_c2", 1'b1, 1'b0);
        stepchk("t2_c3", 1'b1, 1'b0);
        stepchk("t2_c4", 1'b1, 1'b1);
        chk("t2_div", {28'b0, bus.div_cur}, 32'd3);
        bus.select_req = 1'b0;
        stepchk("t2_c5", 1'b1, 1'b1);
        stepchk("t2_c6", 1'b0, 1'b1);
        stepchk("t2_c7", 1'b0, 1'b0);
        stepchk("t2_c8", 1'b1, 1'b0);
        stepchk("t2_c9", 1'b0, 1'b0);
        stepchk("t2_c10", 1'b0, 1'b0);
        stepchk("t2_c11", 1'b1, 1'b0);

        // 5 running, request 2 at cnt=1
        handshake(4'd5);
        wait_hi("t3_sync");
        bus.select_div = 4'd2;
        bus.select_req = 1'b1;
        stepchk("t3_k2", 1'b0, 1'b0);
        stepchk("t3_k3", 1'b0, 1'b0);
        stepchk("t3_k4", 1'b0, 1'b0);
        chk("t3_div_before", {28'b0, bus.div_cur}, 32'd5);
        stepchk("t3_k5", 1'b0, 1'b1);
        chk("t3_div_after", {28'b0, bus.div_cur}, 32'd2);
        bus.select_req = 1'b0;
        stepchk("t3_k6", 1'b1, 1'b1);
        stepchk("t3_k7", 1'b0, 1'b1);
        stepchk("t3_k8", 1'b1, 1'b0);
        stepchk("t3_k9", 1'b0, 1'b0);
        stepchk("t3_k10", 1'b1, 1'b0);

        // stop, then restart at 4
        handshake(4'd0);
        chk("t4_stopped", {31'b0, bus.stopped}, 32'd1);
        for (int i = 0; i < 8; i++) stepchk("t4_held", 1'b0, 1'b0);
        bus.select_div = 4'd4;
        bus.select_req = 1'b1;
        stepchk("t4_s1", 1'b0, 1'b0);
        stepchk("t4_s2", 1'b0, 1'b0);
        stepchk("t4_s3", 1'b0, 1'b0);
        stepchk("t4_s4", 1'b0, 1'b1);
        chk("t4_div", {28'b0, bus.div_cur}, 32'd4);
        chk("t4_running", {31'b0, bus.stopped}, 32'd0);
        bus.select_req = 1'b0;
        stepchk("t4_s5", 1'b1, 1'b1);
        stepchk("t4_s6", 1'b0, 1'b1);
        stepchk("t4_s7", 1'b0, 1'b0);
        stepchk("t4_s8", 1'b0, 1'b0);
        stepchk("t4_s9", 1'b1, 1'b0);
        stepchk("t4_s10", 1'b0, 1'b0);
        stepchk("t4_s11", 1'b0, 1'b0);
        stepchk("t4_s12", 1'b0, 1'b0);
        stepchk("t4_s13", 1'b1, 1'b0);

        // request dropped while waiting for the boundary
        wait_hi("tw_sync");
        bus.select_div = 4'd6;
        bus.select_req = 1'b1;
        stepchk("tw_d1", 1'b0, 1'b0);
        stepchk("tw_d2", 1'b0, 1'b0);
        stepchk("tw_d3", 1'b0, 1'b0);
        bus.select_req = 1'b0;
        stepchk("tw_d4", 1'b1, 1'b0);
        stepchk("tw_d5", 1'b0, 1'b0);
        stepchk("tw_d6", 1'b0, 1'b0);
        stepchk("tw_d7", 1'b0, 1'b1);
        chk("tw_div", {28'b0, bus.div_cur}, 32'd6);
        stepchk("tw_d8", 1'b1, 1'b0);
        measure("tw_spacing", 6);

        // same divisor again
        handshake(4'd6);
        measure("teq_spacing", 6);

        // reset while waiting at divide-by-7, CLK_OUT high
        handshake(4'd7);
        wait_hi("t5_sync");
        for (int i = 0; i < 4; i++) step();
        bus.select_div = 4'd2;
        bus.select_req = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t5_pre_clk", {31'b0, bus.clk_out}, 32'd1);
        chk("t5_pre_div", {28'b0, bus.div_cur}, 32'd7);
        RESETn = 1'b0;
        #1;
        chk("t5_clk_out", {31'b0, bus.clk_out}, 32'd0);
        chk("t5_ack", {31'b0, bus.select_ack}, 32'd0);
        chk("t5_div_rst", {28'b0, bus.div_cur}, 32'd1);
        bus.select_req = 1'b0;
        step();
        RESETn = 1'b1;
        stepchk("t5_rel", 1'b1, 1'b0);
        chk("t5_div_rel", {28'b0, bus.div_cur}, 32'd1);

        // random ratios
        for (int i = 0; i < 10; i++) begin
            d = 4'($urandom_range(0, 15));
            handshake(d);
            if (d == 4'd0) begin
                for (int k = 0; k < 12; k++) stepchk("tr_stop", 1'b0, 1'b0);
            end else begin
                measure("tr_spacing", int'(d));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
